// File: rtl/voice_cmd_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : voice_cmd_tx_if
//  Purpose  : Command handshake bundle between the track/function selection
//             logic and the voice command transmitter.
//  Signals  : cmd_valid  - command present on cmd_op/cmd_arg
//             cmd_ready  - transmitter can accept a command (queue not full)
//             cmd_op     - 8-bit opcode
//             cmd_arg    - argument, ARG_BYTES bytes, MS byte sent first
//  Modports : master (command source), slave (transmitter)
//  Revision : 1.0 - initial release
// ============================================================================
interface voice_cmd_tx_if #(
    parameter int ARG_BYTES = 1
) ();
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [7:0]             cmd_op;
    logic [8*ARG_BYTES-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/voice_cmd_tx.sv
`default_nettype none
// ============================================================================
//  Module   : voice_cmd_tx
//  Purpose  : Queues opcode/argument commands and sends each one as a
//             checksummed frame (7E LEN OP ARG.. CHK EF) on a UART line,
//             8N1/8N2, LSB first, with a forced idle gap between frames.
//  Ports    : clk        - system clock, rising edge
//             rst_n      - synchronous active-low reset
//             cmd        - command handshake (slave side of voice_cmd_tx_if)
//             data_tx    - UART line, idle high (registered)
//             busy       - frame in progress, LOAD through end of GAP
//             frame_done - one-cycle pulse at end of a frame's last stop bit
//             fifo_level - commands currently queued
//  Revision : 1.0 - initial release
// ============================================================================
module voice_cmd_tx #(
    parameter int BAUD_DIV   = 5208,
    parameter int ARG_BYTES  = 1,
    parameter int STOP_BITS  = 1,
    parameter int GAP_BITS   = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    voice_cmd_tx_if.slave               cmd,
    output logic                        data_tx,
    output logic                        busy,
    output logic                        frame_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int N_BYTES = ARG_BYTES + 5;
    localparam int ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = ADDR_W + 1;
    localparam int ENTRY_W = 8 + 8 * ARG_BYTES;
    localparam int BAUD_W  = $clog2(BAUD_DIV);
    localparam int BIT_MAX = (GAP_BITS > 8) ? GAP_BITS : 8;
    localparam int BIT_W   = $clog2(BIT_MAX);
    localparam int BYTE_W  = $clog2(N_BYTES);

    localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  C_DATA_LAST = BIT_W'(7);
    localparam logic [BIT_W-1:0]  C_STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0]  C_GAP_LAST  = BIT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [BYTE_W-1:0] C_BYTE_LAST = BYTE_W'(N_BYTES - 1);
    localparam logic [7:0]        C_LEN       = 8'(ARG_BYTES + 3);
    localparam logic [LVL_W-1:0]  C_FULL      = LVL_W'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q,  level_d;

    logic                 w_ready;
    logic                 w_push;
    logic                 w_pop;
    logic [ENTRY_W-1:0]   w_head;
    logic [7:0]           w_head_op;
    logic [8*ARG_BYTES-1:0] w_head_arg;

    assign w_ready       = (level_q != C_FULL);
    assign cmd.cmd_ready = w_ready;
    assign w_push        = cmd.cmd_valid && w_ready;
    assign w_head        = fifo_mem_q[rd_ptr_q];
    assign w_head_op     = w_head[ENTRY_W-1 -: 8];
    assign w_head_arg    = w_head[8*ARG_BYTES-1:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        // Simultaneous push and pop leaves the level unchanged.
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage has no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= {cmd.cmd_op, cmd.cmd_arg};
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    logic [2:0]         state_q, state_d;
    logic [BAUD_W-1:0]  baud_q,  baud_d;
    logic [BIT_W-1:0]   bit_q,   bit_d;
    logic [BYTE_W-1:0]  byte_q,  byte_d;
    logic [7:0]         frame_q [N_BYTES];
    logic [7:0]         frame_d [N_BYTES];
    logic               data_tx_q,    data_tx_d;
    logic               busy_q,       busy_d;
    logic               frame_done_q, frame_done_d;

    logic               w_tick;
    logic [7:0]         w_chk;

    assign w_tick = (baud_q == C_BAUD_LAST);

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        byte_d       = byte_q;
        frame_d      = frame_q;
        frame_done_d = 1'b0;
        w_pop        = 1'b0;
        w_chk        = C_LEN ^ w_head_op;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (level_q != '0) begin
                    // The head is popped and the whole frame is captured on
                    // the way into LOAD so later pushes cannot disturb it.
                    w_pop      = 1'b1;
                    state_d    = S_LOAD;
                    frame_d[0] = 8'h7E;
                    frame_d[1] = C_LEN;
                    frame_d[2] = w_head_op;
                    for (int i = 0; i < ARG_BYTES; i++) begin
                        frame_d[3+i] = w_head_arg[8*(ARG_BYTES-1-i) +: 8];
                        w_chk        = w_chk ^ w_head_arg[8*(ARG_BYTES-1-i) +: 8];
                    end
                    frame_d[N_BYTES-2] = w_chk;
                    frame_d[N_BYTES-1] = 8'hEF;
                end
            end
            S_LOAD: begin
                state_d = S_START;
                byte_d  = '0;
                baud_d  = '0;
                bit_d   = '0;
            end
            S_START: begin
                if (w_tick) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    baud_d = '0;
                    if (bit_q == C_DATA_LAST) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    baud_d = '0;
                    if (bit_q == C_STOP_LAST) begin
                        bit_d = '0;
                        if (byte_q != C_BYTE_LAST) begin
                            byte_d  = byte_q + BYTE_W'(1);
                            state_d = S_START;
                        end else begin
                            frame_done_d = 1'b1;
                            // A zero-length gap skips straight back to IDLE.
                            state_d = (GAP_BITS > 0) ? S_GAP : S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    baud_d = '0;
                    if (bit_q == C_GAP_LAST) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state view so the line changes
    // on the same edge the sequencer moves.
    always_comb begin
        data_tx_d = 1'b1;
        if (state_d == S_START) begin
            data_tx_d = 1'b0;
        end else if (state_d == S_DATA) begin
            data_tx_d = frame_q[byte_d][bit_d[2:0]];
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            byte_q       <= '0;
            data_tx_q    <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            for (int i = 0; i < N_BYTES; i++) begin
                frame_q[i] <= 8'h00;
            end
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            byte_q       <= byte_d;
            data_tx_q    <= data_tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            frame_q      <= frame_d;
        end
    end

    assign data_tx    = data_tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign fifo_level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_cmd_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_voice_cmd_tx
//  Purpose  : Directed bench for voice_cmd_tx. Two instances: A (1 arg byte,
//             1 stop bit, 10-bit gap) and B (2 arg bytes, 2 stop bits, no
//             gap), both at 4 clocks per bit with a 4-entry queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_voice_cmd_tx;

    localparam int BD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    voice_cmd_tx_if #(.ARG_BYTES(1)) ifa ();
    voice_cmd_tx_if #(.ARG_BYTES(2)) ifb ();

    logic       tx_a, busy_a, fd_a;
    logic       tx_b, busy_b, fd_b;
    logic [2:0] lvl_a, lvl_b;

    voice_cmd_tx #(
        .BAUD_DIV(BD), .ARG_BYTES(1), .STOP_BITS(1), .GAP_BITS(10), .FIFO_DEPTH(4)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .cmd(ifa.slave),
        .data_tx(tx_a), .busy(busy_a), .frame_done(fd_a), .fifo_level(lvl_a)
    );

    voice_cmd_tx #(
        .BAUD_DIV(BD), .ARG_BYTES(2), .STOP_BITS(2), .GAP_BITS(0), .FIFO_DEPTH(4)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .cmd(ifb.slave),
        .data_tx(tx_b), .busy(busy_b), .frame_done(fd_b), .fifo_level(lvl_b)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic line(input int w);
        return (w == 0) ? tx_a : tx_b;
    endfunction
    function automatic logic fdone(input int w);
        return (w == 0) ? fd_a : fd_b;
    endfunction
    function automatic logic rdy(input int w);
        return (w == 0) ? ifa.cmd_ready : ifb.cmd_ready;
    endfunction

    // Byte 0 of the frame sits in the low byte.
    function automatic logic [63:0] fr(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
        return {8'h00, b6, b5, b4, b3, b2, b1, b0};
    endfunction

    // Called at a negedge; holds valid until accepted, returns at the
    // negedge after the accepting edge with valid dropped.
    task automatic push(input int w, input logic [7:0] op, input logic [15:0] arg);
        int   guard;
        logic acc;
        guard = 0;
        acc   = 1'b0;
        if (w == 0) begin
            ifa.cmd_valid = 1'b1; ifa.cmd_op = op; ifa.cmd_arg = arg[7:0];
        end else begin
            ifb.cmd_valid = 1'b1; ifb.cmd_op = op; ifb.cmd_arg = arg;
        end
        while (!acc && guard < 3000) begin
            acc = (rdy(w) === 1'b1);
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        if (!acc) check("push_timeout", 64'd0, 64'd1);
        if (w == 0) ifa.cmd_valid = 1'b0;
        else        ifb.cmd_valid = 1'b0;
    endtask

    // Counts high cycles (including the current one) until the line is low.
    task automatic wait_low(input int w, input int limit, output int n);
        n = 0;
        while (line(w) !== 1'b0 && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Entered at the negedge of the first start-bit cycle; returns at the
    // negedge where frame_done must be high.
    task automatic rx_frame(input int w, input string tag, input logic [63:0] f,
                            input int nb, input int stop);
        int          per, total, errs;
        logic [63:0] dec;
        per   = (9 + stop) * BD;
        total = nb * per;
        errs  = 0;
        dec   = '0;
        for (int c = 0; c < total; c++) begin
            int   b, o;
            logic e;
            b = c / per;
            o = c % per;
            if (o < BD)          e = 1'b0;
            else if (o < 9 * BD) e = f[b*8 + (o-BD)/BD];
            else                 e = 1'b1;
            if (line(w) !== e)       errs++;
            if (fdone(w) !== 1'b0)   errs++;
            if (o >= BD && o < 9 * BD && (o % BD) == BD / 2)
                dec[b*8 + (o-BD)/BD] = line(w);
            @(negedge clk);
        end
        for (int b = 0; b < nb; b++)
            check($sformatf("%s_byte%0d", tag, b), {56'd0, dec[b*8 +: 8]}, {56'd0, f[b*8 +: 8]});
        check({tag, "_wave"}, 64'(errs), 64'd0);
        check({tag, "_done"}, {63'd0, fdone(w)}, 64'd1);
    endtask

    task automatic wait_idle(input int w, input string tag);
        int g;
        g = 0;
        while (((w == 0) ? busy_a : busy_b) !== 1'b0 && g < 500) begin
            g++;
            @(negedge clk);
        end
        check(tag, {63'd0, (w == 0) ? busy_a : busy_b}, 64'd0);
    endtask

    logic [63:0] fb [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        ifa.cmd_valid = 1'b0; ifa.cmd_op = '0; ifa.cmd_arg = '0;
        ifb.cmd_valid = 1'b0; ifb.cmd_op = '0; ifb.cmd_arg = '0;
        rst_n = 1'b0;
        fb[0] = fr(8'h7E, 8'h05, 8'h0F, 8'h01, 8'h02, 8'h09, 8'hEF);
        fb[1] = fr(8'h7E, 8'h05, 8'h11, 8'h22, 8'h33, 8'h05, 8'hEF);
        fb[2] = fr(8'h7E, 8'h05, 8'h44, 8'h55, 8'h66, 8'h72, 8'hEF);
        fb[3] = fr(8'h7E, 8'h05, 8'h77, 8'h88, 8'h99, 8'h63, 8'hEF);
        fb[4] = fr(8'h7E, 8'h05, 8'hAA, 8'hBB, 8'hCC, 8'hD8, 8'hEF);
        fb[5] = fr(8'h7E, 8'h05, 8'hDD, 8'hEE, 8'hF0, 8'hC6, 8'hEF);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_tx",    {63'd0, tx_a},          64'd1);
        check("rst_ready", {63'd0, ifa.cmd_ready}, 64'd1);
        check("rst_busy",  {63'd0, busy_a},        64'd0);
        check("rst_done",  {63'd0, fd_a},          64'd0);
        check("rst_level", {61'd0, lvl_a},         64'd0);
        check("rst_tx_b",  {63'd0, tx_b},          64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single command: latency and frame content
        push(0, 8'h03, 16'h0001);
        check("lat_level1", {61'd0, lvl_a},  64'd1);
        check("lat_idle",   {63'd0, busy_a}, 64'd0);
        @(negedge clk);
        check("lat_busy",   {63'd0, busy_a}, 64'd1);
        check("lat_level0", {61'd0, lvl_a},  64'd0);
        check("lat_line",   {63'd0, tx_a},   64'd1);
        @(negedge clk);
        rx_frame(0, "f1", fr(8'h7E, 8'h04, 8'h03, 8'h01, 8'h06, 8'hEF, 8'h00), 6, 1);
        @(negedge clk);
        check("f1_pulse", {63'd0, fd_a}, 64'd0);
        wait_idle(0, "f1_idle");

        // Back-to-back commands, inter-frame gap, push/pop at levels 1 and 2
        push(0, 8'h10, 16'h0020);
        push(0, 8'hA5, 16'h00FF);
        check("pp_level1", {61'd0, lvl_a}, 64'd1);
        push(0, 8'h31, 16'h0042);
        check("q_level2", {61'd0, lvl_a}, 64'd2);
        rx_frame(0, "c1", fr(8'h7E, 8'h04, 8'h10, 8'h20, 8'h34, 8'hEF, 8'h00), 6, 1);
        wait_low(0, 200, n);
        check("gap_a", 64'(n), 64'd42);
        rx_frame(0, "c2", fr(8'h7E, 8'h04, 8'hA5, 8'hFF, 8'h5E, 8'hEF, 8'h00), 6, 1);
        push(0, 8'h00, 16'h0000);
        check("gap_level2", {61'd0, lvl_a}, 64'd2);
        wait_idle(0, "c2_idle");
        push(0, 8'hFF, 16'h0080);
        check("pp_level2", {61'd0, lvl_a},         64'd2);
        check("pp_ready",  {63'd0, ifa.cmd_ready}, 64'd1);
        wait_low(0, 50, n);
        rx_frame(0, "c3", fr(8'h7E, 8'h04, 8'h31, 8'h42, 8'h77, 8'hEF, 8'h00), 6, 1);
        wait_low(0, 200, n);
        rx_frame(0, "c4", fr(8'h7E, 8'h04, 8'h00, 8'h00, 8'h04, 8'hEF, 8'h00), 6, 1);
        wait_low(0, 200, n);
        rx_frame(0, "c5", fr(8'h7E, 8'h04, 8'hFF, 8'h80, 8'h7B, 8'hEF, 8'h00), 6, 1);
        wait_idle(0, "c5_idle");

        // Full queue on B with two stop bits and no gap
        fork
            begin
                push(1, 8'h0F, 16'h0102);
                check("b_lvl_c0", {61'd0, lvl_b}, 64'd1);
                push(1, 8'h11, 16'h2233);
                check("b_lvl_c1", {61'd0, lvl_b}, 64'd1);
                push(1, 8'h44, 16'h5566);
                check("b_lvl_c2", {61'd0, lvl_b}, 64'd2);
                push(1, 8'h77, 16'h8899);
                check("b_lvl_c3", {61'd0, lvl_b}, 64'd3);
                push(1, 8'hAA, 16'hBBCC);
                check("b_lvl_c4",  {61'd0, lvl_b},         64'd4);
                check("b_full_rdy", {63'd0, ifb.cmd_ready}, 64'd0);
                push(1, 8'hDD, 16'hEEF0);
                check("b_lvl_c5", {61'd0, lvl_b}, 64'd4);
            end
            begin
                int m;
                wait_low(1, 200, m);
                for (int i = 0; i < 6; i++) begin
                    rx_frame(1, $sformatf("b%0d", i), fb[i], 7, 2);
                    if (i < 5) begin
                        wait_low(1, 200, m);
                        check($sformatf("gap_b%0d", i), 64'(m), 64'd2);
                    end
                end
            end
        join
        wait_idle(1, "b_idle");

        // Reset during DATA of byte 3 with two commands queued
        push(0, 8'h01, 16'h0000);
        push(0, 8'h02, 16'h0000);
        push(0, 8'h03, 16'h0000);
        check("r_level2", {61'd0, lvl_a}, 64'd2);
        repeat (3 * 40 + 4 + 2) @(negedge clk);
        check("r_pre_line", {63'd0, tx_a}, 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("r_line",  {63'd0, tx_a},          64'd1);
        check("r_level", {61'd0, lvl_a},         64'd0);
        check("r_busy",  {63'd0, busy_a},        64'd0);
        check("r_ready", {63'd0, ifa.cmd_ready}, 64'd1);
        rst_n = 1'b1;
        wait_low(0, 300, n);
        check("r_quiet", 64'(n), 64'd300);
        push(0, 8'h5A, 16'h00C3);
        wait_low(0, 20, n);
        rx_frame(0, "r_new", fr(8'h7E, 8'h04, 8'h5A, 8'hC3, 8'h9D, 8'hEF, 8'h00), 6, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/voice_cmd_tx.md
# voice_cmd_tx

Parametrised command-frame transmitter for the serial voice/playback module. Accepts opcode/argument commands through a valid/ready handshake, queues them in an internal FIFO, wraps each in a checksummed frame and shifts it out on a single UART line (8 data bits, no parity, configurable stop bits, LSB first). Sits between the control logic that selects tracks/functions and the voice module's RX pin. It replaces the fixed six-byte select-to-serial chain with one block that has configurable baud divisor, argument width, queue depth and inter-frame gap.

## Interface
- BAUD_DIV, 5208, clk cycles per UART bit (50 MHz / 9600); legal ≥ 2
- ARG_BYTES, 1, argument bytes per frame; legal 1 or 2
- STOP_BITS, 1, stop bits per byte; legal 1 or 2
- GAP_BITS, 10, idle bit-times (line high) forced between frames; legal ≥ 0
- FIFO_DEPTH, 4, command queue entries; power of 2, ≥ 2
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- cmd_valid  input  1  command present on cmd_op/cmd_arg
- cmd_ready  output  1  block can accept a command (FIFO not full)
- cmd_op  input  8  command opcode
- cmd_arg  input  8*ARG_BYTES  argument, most-significant byte sent first
- data_tx  output  1  UART line, idle high
- busy  output  1  frame in progress (LOAD through end of GAP)
- frame_done  output  1  one-cycle pulse at end of last stop bit of a frame
- fifo_level  output  $clog2(FIFO_DEPTH)+1  entries currently queued

## Operation
- Frame = 7E, LEN, OP, ARG bytes (MSB first), CHK, EF; LEN = ARG_BYTES+3; CHK = XOR of LEN, OP and all ARG bytes. Frame length N = ARG_BYTES+5 bytes.
- Push when cmd_valid && cmd_ready at a rising edge. cmd_ready = (fifo_level != FIFO_DEPTH). Simultaneous push and pop allowed at any level; level unchanged.
- FSM states: IDLE, LOAD, START, DATA, STOP, GAP.
  - IDLE: data_tx=1, busy=0. FIFO non-empty → LOAD.
  - LOAD: pop head, build all N frame bytes and CHK into a frame register, byte index=0 → START.
  - START: data_tx=0 for BAUD_DIV cycles → DATA.
  - DATA: 8 bits LSB first, BAUD_DIV cycles each → STOP.
  - STOP: data_tx=1 for STOP_BITS*BAUD_DIV cycles; if byte index < N-1, increment → START; else pulse frame_done → GAP.
  - GAP: data_tx=1 for GAP_BITS*BAUD_DIV cycles (zero cycles if GAP_BITS=0) → IDLE.
- Baud counter counts 0..BAUD_DIV-1, restarted on each state entry; no fractional-baud correction.
- Commands pushed during a frame queue; they do not modify the frame being sent.

## Timing
- Reset (rst_n low at an edge): next state IDLE, data_tx=1, cmd_ready=1, busy=0, frame_done=0, fifo_level=0, FIFO contents discarded. Applies mid-frame: line returns high on the first edge after reset is sampled; the partial frame is abandoned and never resent.
- data_tx, busy and frame_done are registered outputs.
- Latency: command pushed at edge k into an empty FIFO with FSM in IDLE → fifo_level=1 after edge k; LOAD after edge k+1 (busy=1, fifo_level=0); data_tx=0 (start bit) after edge k+2.
- Bytes are back-to-back, with no extra idle between a stop bit and the next start bit.
- Frame duration from start-bit falling edge to frame_done: N*(9+STOP_BITS)*BAUD_DIV cycles. frame_done high for exactly one cycle, coincident with entry to GAP.
- Next frame's start bit begins GAP_BITS*BAUD_DIV + 2 cycles after the frame_done cycle (GAP, IDLE, LOAD).
- Full FIFO: cmd_ready=0; a cmd_valid held high is accepted on the first edge after a pop frees an entry.

## Test plan
- BAUD_DIV=4, ARG_BYTES=1: push op 0x03 arg 0x01 → bytes 7E 04 03 01 06 EF on data_tx; each bit is 4 cycles; start bit 2 cycles after acceptance; frame_done 240 cycles after start-bit fall.
- ARG_BYTES=2, STOP_BITS=2: op 0x0F arg 0x0102 → 7E 05 0F 01 02 09 EF; line high for 8 cycles per stop period (BAUD_DIV=4).
- FIFO_DEPTH=4, hold cmd_valid with 6 distinct commands → cmd_ready drops when 4 are queued (the first has already popped); all 6 frames are sent in order; no command lost or duplicated; fifo_level tracks pushes and pops.
- GAP_BITS=10, BAUD_DIV=4, two queued commands → exactly 42 high cycles from frame_done to the second start bit; GAP_BITS=0 → 2 cycles.
- Assert rst_n low during the DATA state of byte 3 with 2 commands queued → data_tx=1 and fifo_level=0 the next cycle; no further frames; a fresh push afterwards produces a complete correct frame.
- Push and pop in the same cycle with fifo_level=2 → level stays 2; cmd_ready stays 1.
